fifo_uart_tx: RTL and testbench

- Downstream consumer of the team's byte FIFO. Pops one word at a time through the FIFO read handshake (rd_en/rd_val/rd_data) and serialises it as an asynchronous UART frame on a single line.
- Frame format: start bit, data bits LSB first, optional parity bit, stop bit(s).
- Sits between the TX FIFO and the pad; throttles FIFO reads to the line rate.

---
 rtl/fifo_uart_tx.sv | 163 ++++++++++++++++
 tb/tb_fifo_uart_tx.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_uart_tx.sv
`default_nettype none
// ============================================================================
// Module   : fifo_uart_tx
// Function : Pops words from the byte FIFO through its read handshake and
//            serialises each one as a UART frame (start, LSB-first data,
//            optional even parity, stop bits). Reads are throttled to the
//            line rate, so there is exactly one pop per frame.
// Option   : FIFO_UART_TX_PARITY_EN inserts an even-parity bit after DATA.
// Revision : 1.0 - initial release
// ============================================================================
module fifo_uart_tx #(
  parameter int DATA_WIDTH   = 8,
  parameter int CLKS_PER_BIT = 16,
  parameter int STOP_BITS    = 1,
  parameter int CNT_W        = $clog2(CLKS_PER_BIT*STOP_BITS)+1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  tx_en,
  input  logic                  rd_val,
  input  logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_en,
  output logic                  tx,
  output logic                  busy,
  output logic                  tx_done
);

  localparam int IDX_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  // Terminal counts; the stop period is at least two cycles long because
  // CLKS_PER_BIT >= 2, so STOP_PRE is always a reachable count.
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] STOP_LAST = CNT_W'(CLKS_PER_BIT*STOP_BITS - 1);
  localparam logic [CNT_W-1:0] STOP_PRE  = CNT_W'(CLKS_PER_BIT*STOP_BITS - 2);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD   = 3'd1,
    START  = 3'd2,
    DATA   = 3'd3,
    PARITY = 3'd4,
    STOP   = 3'd5
  } state_t;

  state_t                  state;
  logic [CNT_W-1:0]        cnt;
  logic [IDX_W-1:0]        bit_idx;
  logic [DATA_WIDTH-1:0]   shreg;
  logic [DATA_WIDTH-1:0]   shreg_next;
`ifdef FIFO_UART_TX_PARITY_EN
  logic                    parity;
`endif

  // Pop only from IDLE so a frame in flight can never consume a second word.
  assign rd_en      = (state == IDLE) & tx_en & rd_val & ~reset;
  assign busy       = (state != IDLE) | rd_en;
  assign shreg_next = shreg >> 1;

  // Frame sequencer; tx and tx_done are registered so the line never glitches.
  // tx is loaded one cycle ahead, at each transition, with the level of the
  // bit that is about to start.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      cnt     <= '0;
      bit_idx <= '0;
      shreg   <= '0;
      tx      <= 1'b1;
      tx_done <= 1'b0;
`ifdef FIFO_UART_TX_PARITY_EN
      parity  <= 1'b0;
`endif
    end else begin
      tx_done <= 1'b0;
      case (state)
        IDLE: begin
          tx      <= 1'b1;
          cnt     <= '0;
          bit_idx <= '0;
          if (rd_en) begin
            state <= LOAD;
          end
        end

        LOAD: begin
          // rd_data is valid only in this cycle, one cycle after the pop.
          shreg  <= rd_data;
`ifdef FIFO_UART_TX_PARITY_EN
          parity <= ^rd_data;
`endif
          tx     <= 1'b0;
          state  <= START;
        end

        START: begin
          if (cnt == BIT_LAST) begin
            cnt   <= '0;
            tx    <= shreg[0];
            state <= DATA;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end

        DATA: begin
          if (cnt == BIT_LAST) begin
            cnt   <= '0;
            shreg <= shreg_next;
            if (bit_idx == IDX_LAST) begin
              bit_idx <= '0;
`ifdef FIFO_UART_TX_PARITY_EN
              tx      <= parity;
              state   <= PARITY;
`else
              tx      <= 1'b1;
              state   <= STOP;
`endif
            end else begin
              bit_idx <= bit_idx + IDX_W'(1);
              tx      <= shreg_next[0];
            end
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end

`ifdef FIFO_UART_TX_PARITY_EN
        PARITY: begin
          if (cnt == BIT_LAST) begin
            cnt   <= '0;
            tx    <= 1'b1;
            state <= STOP;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
`endif

        STOP: begin
          // Raise tx_done one cycle early so it lands on the last stop cycle.
          if (cnt == STOP_PRE) begin
            tx_done <= 1'b1;
          end
          if (cnt == STOP_LAST) begin
            cnt   <= '0;
            state <= IDLE;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end

        default: begin
          tx    <= 1'b1;
          cnt   <= '0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fifo_uart_tx.sv
`default_nettype none
// ============================================================================
// Module   : tb_fifo_uart_tx
// Function : Self-checking bench for fifo_uart_tx. A queue models the FIFO;
//            each expected frame is built from the data word as a list of
//            line levels (start, data LSB first, parity, stop) and the line
//            is compared bit period by bit period.
// Option   : honours FIFO_UART_TX_PARITY_EN like the design.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fifo_uart_tx;

  localparam int DW = 8;
  localparam int C  = 4;
  localparam int SB = 1;
`ifdef FIFO_UART_TX_PARITY_EN
  localparam int P  = 1;
`else
  localparam int P  = 0;
`endif
  localparam int FRAME_LEN = (1 + DW + P + SB) * C;

  logic          clk    = 1'b0;
  logic          reset  = 1'b1;
  logic          tx_en  = 1'b1;
  logic          rd_val = 1'b0;
  logic [DW-1:0] rd_data = '0;
  logic          rd_en, tx, busy, tx_done;

  int            total = 0;
  int            passed = 0;
  int            pops = 0;
  logic          pop_seen;
  logic [DW-1:0] fifo_q[$];

  typedef struct packed {
    logic [DW-1:0] data;
    logic          par;
  } vec_t;
  vec_t vecs[6];

  fifo_uart_tx #(
    .DATA_WIDTH  (DW),
    .CLKS_PER_BIT(C),
    .STOP_BITS   (SB)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .tx_en  (tx_en),
    .rd_val (rd_val),
    .rd_data(rd_data),
    .rd_en  (rd_en),
    .tx     (tx),
    .busy   (busy),
    .tx_done(tx_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // FIFO model: a pop seen mid-cycle presents its word just after the edge;
  // in all other cycles rd_data carries noise the design must ignore.
  initial begin
    forever begin
      @(negedge clk); #1;
      pop_seen = rd_en;
      @(posedge clk); #1;
      if (pop_seen === 1'b1) begin
        pops++;
        if (fifo_q.size() > 0) rd_data = fifo_q.pop_front();
        else rd_data = DW'($urandom);
      end else begin
        rd_data = DW'($urandom);
      end
      rd_val = (fifo_q.size() != 0);
    end
  end

  // Waits (bounded) until rd_en is high at a negedge; budget 0 means "now".
  task automatic wait_pop(input int budget, input string name);
    int n = 0;
    while (rd_en !== 1'b1 && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk(name, {31'b0, rd_en}, 32'd1);
  endtask

  // Called at the negedge of the pop cycle; returns at the last stop cycle.
  task automatic expect_frame(input logic [DW-1:0] d, input logic par, input string tag);
    logic bits[$];
    int   cyc = 0, done_cnt = 0, done_at = -1, bad_busy = 0, bad_rden = 0;
    chk({tag, " busy@pop"}, {31'b0, busy}, 32'd1);
    @(negedge clk);
    chk({tag, " tx@load"}, {31'b0, tx}, 32'd1);
    chk({tag, " busy@load"}, {31'b0, busy}, 32'd1);
    bits.push_back(1'b0);
    for (int i = 0; i < DW; i++) bits.push_back(d[i]);
    for (int i = 0; i < P; i++) bits.push_back(par);
    for (int i = 0; i < SB; i++) bits.push_back(1'b1);
    for (int b = 0; b < bits.size(); b++) begin
      int ok = 0;
      for (int k = 0; k < C; k++) begin
        @(negedge clk);
        cyc++;
        if (tx === bits[b]) ok++;
        if (busy !== 1'b1) bad_busy++;
        if (rd_en !== 1'b0) bad_rden++;
        if (tx_done === 1'b1) begin
          done_cnt++;
          done_at = cyc;
        end
      end
      chk($sformatf("%s d=%02h bit%0d tx cycles", tag, d, b), ok, C);
    end
    chk({tag, " busy drop"}, bad_busy, 0);
    chk({tag, " rd_en in frame"}, bad_rden, 0);
    chk({tag, " tx_done count"}, done_cnt, 1);
    chk({tag, " tx_done cycle"}, done_at, FRAME_LEN);
  endtask

  // Counts cycles where the line is not quietly idle.
  task automatic expect_idle(input int cycles, input string name);
    int bad = 0;
    repeat (cycles) begin
      @(negedge clk);
      if (tx !== 1'b1 || busy !== 1'b0 || rd_en !== 1'b0 || tx_done !== 1'b0) bad++;
    end
    chk(name, bad, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL timeout: bench did not finish, got running expected finished");
    $fatal(1);
  end

  initial begin
    int            p0;
    logic [DW-1:0] rb;
    logic [DW-1:0] model[$];

    vecs[0] = '{data: 8'hA5, par: 1'b0};
    vecs[1] = '{data: 8'h07, par: 1'b1};
    vecs[2] = '{data: 8'h03, par: 1'b0};
    vecs[3] = '{data: 8'h80, par: 1'b1};
    vecs[4] = '{data: 8'h5A, par: 1'b0};
    vecs[5] = '{data: 8'h01, par: 1'b1};

    // Reset behaviour, then a long quiet stretch with the FIFO empty.
    repeat (3) @(negedge clk);
    chk("reset tx", {31'b0, tx}, 32'd1);
    chk("reset rd_en", {31'b0, rd_en}, 32'd0);
    chk("reset busy", {31'b0, busy}, 32'd0);
    chk("reset tx_done", {31'b0, tx_done}, 32'd0);
    reset = 1'b0;
    expect_idle(20, "idle after reset");

    // Table of single words, each sent from an otherwise empty FIFO.
    p0 = pops;
    for (int v = 0; v < 6; v++) begin
      fifo_q.push_back(vecs[v].data);
      wait_pop(20, "table pop");
      expect_frame(vecs[v].data, vecs[v].par, "table");
      @(negedge clk);
      chk("table idle after frame", {31'b0, busy}, 32'd0);
    end
    chk("table pop count", pops - p0, 6);

    // Back-to-back: the next pop follows the last stop cycle immediately.
    p0 = pops;
    fifo_q.push_back(8'h00);
    fifo_q.push_back(8'hFF);
    wait_pop(20, "b2b first pop");
    expect_frame(8'h00, 1'b0, "b2b0");
    @(negedge clk);
    wait_pop(0, "b2b gap pop");
    expect_frame(8'hFF, 1'b0, "b2b1");
    expect_idle(4, "b2b idle after");
    chk("b2b pop count", pops - p0, 2);
    chk("b2b fifo empty", fifo_q.size(), 0);

    // tx_en dropped mid-DATA: frame completes, no further pop until re-enabled.
    p0 = pops;
    fifo_q.push_back(8'h3C);
    fifo_q.push_back(8'hC3);
    wait_pop(20, "txen pop");
    fork
      expect_frame(8'h3C, 1'b0, "txen");
      begin
        repeat (20) @(negedge clk);
        tx_en = 1'b0;
      end
    join
    expect_idle(10, "txen held off");
    chk("txen single pop", pops - p0, 1);
    tx_en = 1'b1;
    #1;
    wait_pop(2, "txen resume pop");
    expect_frame(8'hC3, 1'b0, "txen2");
    expect_idle(2, "txen idle after");

    // Reset during data bit 3 of an all-zero word.
    p0 = pops;
    fifo_q.push_back(8'h00);
    wait_pop(20, "rst pop");
    repeat (19) @(negedge clk);
    chk("rst tx in bit3", {31'b0, tx}, 32'd0);
    reset = 1'b1;
    @(negedge clk);
    chk("rst tx next cycle", {31'b0, tx}, 32'd1);
    chk("rst busy next cycle", {31'b0, busy}, 32'd0);
    reset = 1'b0;
    expect_idle(12, "rst no reread");
    chk("rst pop count", pops - p0, 1);
    fifo_q.push_back(8'hE1);
    wait_pop(20, "rst fresh pop");
    expect_frame(8'hE1, 1'b0, "rst fresh");

    // Random burst against the reference frame builder.
    for (int i = 0; i < 6; i++) begin
      rb = DW'($urandom);
      model.push_back(rb);
      fifo_q.push_back(rb);
    end
    @(negedge clk);
    wait_pop(20, "rand first pop");
    for (int i = 0; i < 6; i++) begin
      expect_frame(model[i], ^model[i], "rand");
      if (i < 5) begin
        @(negedge clk);
        wait_pop(0, "rand b2b pop");
      end
    end
    expect_idle(4, "rand idle after");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
`default_nettype wire
